// File: rtl/ins_loader_if.sv
// Byte-stream and instruction-memory write bus of the instruction loader.
// The host side (master) drives bytes and observes the memory writes; the
// loader side (slave) accepts bytes and produces the write strobe/address/data.
interface ins_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/ins_loader.sv
// Instruction-memory loader: receives a framed byte image (2-byte big-endian
// word count, payload, XOR checksum byte), assembles big-endian 32-bit words
// and writes them sequentially from BASE_ADDR. The CPU is held until an image
// with a good checksum has been loaded completely.
module ins_loader #(
  parameter int          DEPTH_W   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  ins_loader_if.slave  bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  // Largest legal word count; 17 bits so 2^16 is representable.
  localparam logic [16:0] MAX_LEN = 17'd1 << DEPTH_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHK    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // Running XOR checksum update.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t      state_r;
  state_t      next_state_s;

  logic [15:0] len_r;
  logic [1:0]  byte_cnt_r;
  logic [31:0] word_r;
  logic [16:0] word_cnt_r;
  logic [7:0]  acc_r;

  logic        in_ready_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        cpu_hold_r;
  logic        done_r;
  logic        err_r;

  logic        xfer_s;
  logic        session_start_s;
  logic [15:0] len_full_s;
  logic [31:0] word_next_s;
  logic [7:0]  acc_next_s;
  logic        last_word_s;

  logic        in_ready_s;
  logic        mem_we_s;
  logic        cpu_hold_s;
  logic        done_s;
  logic        err_s;

  assign xfer_s          = bus.in_valid && in_ready_r;
  assign session_start_s = start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERR));
  assign len_full_s      = {len_r[15:8], bus.in_data};
  assign word_next_s     = {word_r[23:0], bus.in_data};
  assign acc_next_s      = chk_update(acc_r, bus.in_data);
  assign last_word_s     = ((word_cnt_r + 17'd1) == {1'b0, len_r});

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_LEN_HI;
        else       next_state_s = S_IDLE;
      end
      S_LEN_HI: begin
        if (xfer_s) next_state_s = S_LEN_LO;
        else        next_state_s = S_LEN_HI;
      end
      S_LEN_LO: begin
        if (!xfer_s)                           next_state_s = S_LEN_LO;
        else if ({1'b0, len_full_s} > MAX_LEN) next_state_s = S_ERR;
        else if (len_full_s == 16'd0)          next_state_s = S_CHK;
        else                                   next_state_s = S_DATA;
      end
      S_DATA: begin
        if (xfer_s && (byte_cnt_r == 2'd3)) next_state_s = S_WRITE;
        else                                next_state_s = S_DATA;
      end
      S_WRITE: begin
        if (last_word_s) next_state_s = S_CHK;
        else             next_state_s = S_DATA;
      end
      S_CHK: begin
        if (!xfer_s)                  next_state_s = S_CHK;
        else if (acc_next_s == 8'h00) next_state_s = S_DONE;
        else                          next_state_s = S_ERR;
      end
      S_DONE: begin
        if (start) next_state_s = S_LEN_HI;
        else       next_state_s = S_DONE;
      end
      S_ERR: begin
        if (start) next_state_s = S_LEN_HI;
        else       next_state_s = S_ERR;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    in_ready_s = 1'b0;
    mem_we_s   = 1'b0;
    cpu_hold_s = 1'b1;
    done_s     = 1'b0;
    err_s      = 1'b0;
    case (next_state_s)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: in_ready_s = 1'b1;
      S_WRITE:                           mem_we_s   = 1'b1;
      S_DONE: begin
        cpu_hold_s = 1'b0;
        done_s     = 1'b1;
      end
      S_ERR:                             err_s      = 1'b1;
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Length, word assembly, counters and checksum accumulator.
  always_ff @(posedge clk) begin
    if (rst || session_start_s) begin
      len_r      <= 16'd0;
      byte_cnt_r <= 2'd0;
      word_r     <= 32'd0;
      word_cnt_r <= 17'd0;
      acc_r      <= 8'd0;
    end else begin
      if (xfer_s) acc_r <= acc_next_s;
      case (state_r)
        S_LEN_HI: if (xfer_s) len_r[15:8] <= bus.in_data;
        S_LEN_LO: if (xfer_s) len_r[7:0]  <= bus.in_data;
        S_DATA: begin
          if (xfer_s) begin
            word_r     <= word_next_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
          end
        end
        S_WRITE: word_cnt_r <= word_cnt_r + 17'd1;
        default: ;
      endcase
    end
  end

  // Registered outputs; address/data are captured as the write state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= BASE_ADDR;
      mem_wdata_r <= 32'd0;
      cpu_hold_r  <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      in_ready_r <= in_ready_s;
      mem_we_r   <= mem_we_s;
      cpu_hold_r <= cpu_hold_s;
      done_r     <= done_s;
      err_r      <= err_s;
      if (mem_we_s) begin
        mem_addr_r  <= BASE_ADDR + {13'd0, word_cnt_r, 2'b00};
        mem_wdata_r <= word_next_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign cpu_hold      = cpu_hold_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: a table of framed images with known
// results, hand-written reset/latency sequences, and randomized images checked
// against a frame-level reference model.
module tb_ins_loader;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef struct {
    int               nb;
    logic [0:15][7:0] b;
    int               exp_acc;
    int               exp_nw;
    logic [31:0]      a0, d0, a1, d1;
    bit               exp_done;
    bit               exp_err;
  } vec_t;

  logic clk;
  logic rst;
  logic start;
  logic cpu_hold, done, err;
  int   n_cmp, n_bad;
  int   cyc;
  wr_t  wr_q[$];
  int   wr_cyc_q[$];
  wr_t  exp_q[$];
  int   acc_cyc[$];

  ins_loader_if bus();

  ins_loader #(.DEPTH_W(8), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe seen by the memory.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_q.push_back('{addr: bus.mem_addr, data: bus.mem_wdata});
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte until accepted or the bound expires; gaps/stray starts optional.
  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
    bit v, took;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      v = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = b;
      start = gaps && ($urandom_range(3, 0) == 0);
      took = v && (bus.in_ready === 1'b1);
      tick();
      if (took) begin
        ok = 1'b1;
        acc_cyc.push_back(cyc);
        break;
      end
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_session(input byte_q_t s, input bit gaps, output int acc_n);
    bit ok;
    wr_q.delete();
    wr_cyc_q.delete();
    acc_cyc.delete();
    pulse_start();
    acc_n = 0;
    foreach (s[i]) begin
      send_byte(s[i], gaps, ok);
      if (!ok) break;
      acc_n++;
    end
    repeat (3) tick();
  endtask

  task automatic compare_session(input string nm, input int acc_n, input int exp_acc,
                                 input bit exp_done, input bit exp_err);
    chk({nm, ".accepted"}, acc_n, exp_acc);
    chk({nm, ".nwrites"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk($sformatf("%s.addr%0d", nm, i), wr_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s.data%0d", nm, i), wr_q[i].data, exp_q[i].data);
    end
    chk({nm, ".done"}, done, exp_done);
    chk({nm, ".err"}, err, exp_err);
    chk({nm, ".cpu_hold"}, cpu_hold, !exp_done);
    chk({nm, ".in_ready"}, bus.in_ready, 1'b0);
  endtask

  // Frame-level reference: decode count, split payload into big-endian words,
  // image good iff the XOR of every byte (checksum included) is zero.
  task automatic model(input byte_q_t s, output int acc_n, output bit d, output bit e);
    int len;
    logic [7:0] x;
    exp_q.delete();
    len = int'({s[0], s[1]});
    if (len > 256) begin
      acc_n = 2; d = 1'b0; e = 1'b1;
      return;
    end
    acc_n = 2 + 4 * len + 1;
    for (int k = 0; k < len; k++)
      exp_q.push_back('{addr: 32'(4 * k),
                        data: {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]}});
    x = 8'h00;
    for (int i = 0; i < acc_n; i++) x = x ^ s[i];
    d = (x == 8'h00);
    e = !d;
  endtask

  vec_t    tbl [7];
  byte_q_t s;
  int      acc_n, exp_acc;
  bit      ed, ee;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;

    // Good image: checksum 0x57 is the XOR of the ten preceding bytes.
    tbl[0] = '{nb: 11, b: {8'h00,8'h02,8'h20,8'h08,8'h00,8'h05,8'h01,8'h09,8'h50,8'h20,8'h57,{5{8'h00}}},
               exp_acc: 11, exp_nw: 2, a0: 32'h0, d0: 32'h2008_0005, a1: 32'h4, d1: 32'h0109_5020,
               exp_done: 1'b1, exp_err: 1'b0};
    tbl[1] = tbl[0]; tbl[1].b[10] = 8'h5E; tbl[1].exp_done = 1'b0; tbl[1].exp_err = 1'b1;
    tbl[2] = tbl[0]; tbl[2].b[10] = 8'h5F; tbl[2].exp_done = 1'b0; tbl[2].exp_err = 1'b1;
    tbl[3] = '{nb: 2, b: {8'h01,8'h01,{14{8'h00}}}, exp_acc: 2, exp_nw: 0,
               a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0, exp_done: 1'b0, exp_err: 1'b1};
    tbl[4] = '{nb: 3, b: {8'h00,8'h00,8'h00,{13{8'h00}}}, exp_acc: 3, exp_nw: 0,
               a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0, exp_done: 1'b1, exp_err: 1'b0};
    tbl[5] = tbl[4]; tbl[5].b[2] = 8'h01; tbl[5].exp_done = 1'b0; tbl[5].exp_err = 1'b1;
    tbl[6] = '{nb: 7, b: {8'h00,8'h01,8'hDE,8'hAD,8'hBE,8'hEF,8'h23,{9{8'h00}}}, exp_acc: 7, exp_nw: 1,
               a0: 32'h0, d0: 32'hDEAD_BEEF, a1: 32'h0, d1: 32'h0, exp_done: 1'b1, exp_err: 1'b0};

    // Reset state, held while idle.
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("rst.in_ready", bus.in_ready, 1'b0);
    chk("rst.cpu_hold", cpu_hold, 1'b1);
    chk("rst.done", done, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst.mem_we_count", wr_q.size(), 0);
    chk("rst.mem_addr", bus.mem_addr, 32'h0);
    chk("rst.mem_wdata", bus.mem_wdata, 32'h0);

    // Table-driven images.
    for (int v = 0; v < 7; v++) begin
      s.delete();
      for (int i = 0; i < tbl[v].nb; i++) s.push_back(tbl[v].b[i]);
      exp_q.delete();
      if (tbl[v].exp_nw > 0) exp_q.push_back('{addr: tbl[v].a0, data: tbl[v].d0});
      if (tbl[v].exp_nw > 1) exp_q.push_back('{addr: tbl[v].a1, data: tbl[v].d1});
      run_session(s, 1'b0, acc_n);
      compare_session($sformatf("vec%0d", v), acc_n, tbl[v].exp_acc, tbl[v].exp_done, tbl[v].exp_err);
      if (v == 0 && wr_cyc_q.size() == 2 && acc_cyc.size() >= 6) begin
        chk("latency.first_write", wr_cyc_q[0], acc_cyc[5]);
        chk("throughput.word_spacing", wr_cyc_q[1] - wr_cyc_q[0], 5);
      end
    end

    // Same good image with random valid gaps and stray start pulses.
    s.delete();
    for (int i = 0; i < 11; i++) s.push_back(tbl[0].b[i]);
    model(s, exp_acc, ed, ee);
    run_session(s, 1'b1, acc_n);
    compare_session("gaps", acc_n, exp_acc, ed, ee);

    // Reset after three payload bytes aborts the session without a write.
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      bit ok;
      send_byte(tbl[0].b[i], 1'b0, ok);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    repeat (6) tick();
    bus.in_valid = 1'b0;
    chk("abort.nwrites", wr_q.size(), 0);
    chk("abort.in_ready", bus.in_ready, 1'b0);
    chk("abort.cpu_hold", cpu_hold, 1'b1);
    chk("abort.done", done, 1'b0);
    chk("abort.err", err, 1'b0);
    run_session(s, 1'b0, acc_n);
    compare_session("after_abort", acc_n, exp_acc, ed, ee);

    // Randomized images against the reference model.
    for (int r = 0; r < 20; r++) begin
      int len, kind;
      logic [7:0] x;
      kind = $urandom_range(9, 0);
      if (r == 0)        len = 256;
      else if (kind < 7) len = $urandom_range(6, 0);
      else if (kind < 8) len = 256;
      else               len = $urandom_range(65535, 257);
      s.delete();
      s.push_back(8'(len >> 8));
      s.push_back(8'(len));
      if (len <= 256) begin
        for (int i = 0; i < 4 * len; i++) s.push_back(8'($urandom));
        x = 8'h00;
        foreach (s[i]) x = x ^ s[i];
        if ($urandom_range(9, 0) < 3) x = x ^ 8'($urandom_range(255, 1));
        s.push_back(x);
      end
      model(s, exp_acc, ed, ee);
      run_session(s, 1'($urandom_range(1, 0)), acc_n);
      compare_session($sformatf("rand%0d", r), acc_n, exp_acc, ed, ee);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
